// File: rtl/tt_um_michaelbell_tinyqv_core.sv
// tt_um_michaelbell_tinyqv_core: QSPI flash fast-read (0x6B) streamed out as UART 8N1.
// Optional SPI_MIRROR_EN also mirrors every byte onto the SPI pins (mode 0, clk/2).
module tt_um_michaelbell_tinyqv_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int READ_LEN = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [15:0] LEN = 16'(READ_LEN);
    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, WAIT, DONE} state_t;

    state_t      state;
    logic        cs_n, sck, hi;
    logic [7:0]  sr, rx;
    logic [4:0]  cnt;
    logic [2:0]  lat;
    logic [15:0] byte_cnt;
    logic        tx_active, uart_tx;
    logic [8:0]  tx_sr;
    logic [3:0]  tx_bits;
    logic [15:0] tx_clk;
    logic        spi_cs, spi_sck, spi_mosi, spi_dc, spi_idle;
    logic        accept, busy, oe_d0;
    logic [3:0]  q;
    logic        unused_ok;

    assign q = {uio_in[5:4], uio_in[2:1]};
    assign accept = state == WAIT && !tx_active && spi_idle;
    assign busy = state != IDLE && state != DONE;
    assign oe_d0 = state == CMD || state == ADDR;
    assign uo_out = {1'b0, state == DONE, busy, uart_tx, spi_dc, spi_mosi, spi_sck, spi_cs};
    assign uio_out = {2'b11, 2'b00, sck, 1'b0, sr[7], cs_n};
    assign uio_oe = {2'b11, 2'b00, 1'b1, 1'b0, oe_d0, 1'b1};
    assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in[7:6], uio_in[3], uio_in[0]};

    // sr carries the command; once it has shifted out it is zero, which is the address
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            cs_n <= 1'b1;
            sck <= 1'b0;
            hi <= 1'b0;
            sr <= 8'h00;
            rx <= 8'h00;
            cnt <= 5'd0;
            byte_cnt <= 16'd0;
            lat <= {uio_in[4], uio_in[2:1]};
        end else begin
            case (state)
                IDLE: if (ui_in[0]) begin
                    state <= CMD;
                    cs_n <= 1'b0;
                    sr <= 8'h6B;
                end
                CMD, ADDR, DUMMY, DATA: begin
                    sck <= !sck;
                    if (sck) begin
                        cnt <= cnt + 5'd1;
                        sr <= sr << 1;
                        if (state == CMD && cnt == 5'd7) begin
                            state <= ADDR;
                            cnt <= 5'd0;
                        end
                        if (state == ADDR && cnt == 5'd23) begin
                            state <= DUMMY;
                            cnt <= 5'd0;
                        end
                        if (state == DUMMY && cnt == {2'b00, lat}) begin
                            state <= DATA;
                            cnt <= 5'd0;
                        end
                        if (state == DATA) begin
                            hi <= !hi;
                            rx <= {rx[3:0], q};
                            if (hi) state <= WAIT;
                        end
                    end
                end
                WAIT: if (accept) begin
                    byte_cnt <= byte_cnt + 16'd1;
                    if (byte_cnt + 16'd1 == LEN) begin
                        state <= DONE;
                        cs_n <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Start bit goes out straight after acceptance; tx_sr holds data then stop bit
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_active <= 1'b0;
            uart_tx <= 1'b1;
            tx_sr <= 9'h000;
            tx_bits <= 4'd0;
            tx_clk <= 16'd0;
        end else if (accept) begin
            tx_active <= 1'b1;
            uart_tx <= 1'b0;
            tx_sr <= {1'b1, rx};
            tx_bits <= 4'd9;
            tx_clk <= 16'd0;
        end else if (tx_active) begin
            tx_clk <= tx_clk == BIT_END ? 16'd0 : tx_clk + 16'd1;
            if (tx_clk == BIT_END) begin
                if (tx_bits == 4'd0) begin
                    tx_active <= 1'b0;
                end else begin
                    uart_tx <= tx_sr[0];
                    tx_sr <= tx_sr >> 1;
                    tx_bits <= tx_bits - 4'd1;
                end
            end
        end
    end

`ifdef SPI_MIRROR_EN
    logic [7:0] spi_sr;
    logic [2:0] spi_cnt;
    logic       spi_active;

    assign spi_mosi = spi_sr[7];
    assign spi_dc = !spi_cs;
    assign spi_idle = !spi_active;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            spi_active <= 1'b0;
            spi_cs <= 1'b1;
            spi_sck <= 1'b0;
            spi_sr <= 8'h00;
            spi_cnt <= 3'd0;
        end else if (accept) begin
            spi_active <= 1'b1;
            spi_cs <= 1'b0;
            spi_sck <= 1'b0;
            spi_sr <= rx;
            spi_cnt <= 3'd0;
        end else if (spi_active) begin
            spi_sck <= !spi_sck;
            if (spi_sck) begin
                spi_sr <= spi_sr << 1;
                spi_cnt <= spi_cnt + 3'd1;
                if (spi_cnt == 3'd7) begin
                    spi_active <= 1'b0;
                    spi_cs <= 1'b1;
                end
            end
        end
    end
`else
    assign spi_cs = 1'b1;
    assign spi_sck = 1'b0;
    assign spi_mosi = 1'b0;
    assign spi_dc = 1'b0;
    assign spi_idle = 1'b1;
`endif
endmodule

// File: tb/tb_tt_um_michaelbell_tinyqv_core.sv
// tb_tt_um_michaelbell_tinyqv_core: directed bench with a QSPI flash model and UART decoder.
module tb_tt_um_michaelbell_tinyqv_core;
    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
    logic [3:0] nib = 4'h0;
    logic [7:0] cmd = 8'h00;
    logic [23:0] addr = 24'hFFFFFF;
    logic       cs_prev = 1'b1;
    int         sck_cnt = 0;
    int         cs_falls = 0;
    int         inv_bad = 0;
    int         checks = 0;
    int         failures = 0;
    int         n;
    logic [7:0] tbl [4] = '{8'hA5, 8'h3C, 8'h81, 8'h5A};
    localparam logic [2:0] CFG = 3'd3;

    always #5 clk = ~clk;

    assign uio_in = rst_n ? {3'b000, CFG[2], 1'b0, CFG[1:0], 1'b0}
                          : {2'b00, nib[3:2], 1'b0, nib[1:0], 1'b0};

    tt_um_michaelbell_tinyqv_core #(.CLKS_PER_BIT(16), .READ_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    // Flash model: counts SCK-high clocks since CS fell; data follows 4 dummy cycles
    always @(negedge clk) begin
        cs_prev <= uio_out[0];
        if (cs_prev && !uio_out[0]) cs_falls <= cs_falls + 1;
        if (uio_out[0]) sck_cnt <= 0;
        else if (uio_out[3]) begin
            sck_cnt <= sck_cnt + 1;
            if (sck_cnt < 8) cmd <= {cmd[6:0], uio_out[1]};
            else if (sck_cnt < 32) addr <= {addr[22:0], uio_out[1]};
            else if (sck_cnt >= 36 && sck_cnt < 44)
                nib <= sck_cnt[0] ? tbl[2'((sck_cnt - 36) >> 1)][3:0] : tbl[2'((sck_cnt - 36) >> 1)][7:4];
        end
        if (uio_out[7:6] !== 2'b11 || uio_oe[1] !== (!uio_out[0] && sck_cnt < 32) || uo_out[7] !== 1'b0)
            inv_bad <= inv_bad + 1;
`ifndef SPI_MIRROR_EN
        if (uo_out[3:0] !== 4'b0001) inv_bad <= inv_bad + 1;
`endif
    end

`ifdef SPI_MIRROR_EN
    logic [7:0] spi_sh = 8'h00, spi_last = 8'h00;
    int spi_len = 0, spi_len_last = 0;
    logic spi_prev = 1'b1;
    always @(negedge clk) begin
        spi_prev <= uo_out[0];
        if (!uo_out[0]) begin
            spi_len <= spi_len + 1;
            if (uo_out[1]) spi_sh <= {spi_sh[6:0], uo_out[2]};
            if (uo_out[3] !== 1'b1) inv_bad <= inv_bad + 1;
        end else if (!spi_prev) begin
            spi_last <= spi_sh;
            spi_len_last <= spi_len;
            spi_len <= 0;
        end
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit, samples 160 clocks of uart_tx and decodes mid-bit
    task automatic rx_byte(input string tag, input logic [7:0] exp, input bit timing);
        logic samp [160];
        logic [7:0] b;
        int w;
        w = 0;
        while (uo_out[4] !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_start_seen"}, 32'(w < 4000), 32'd1);
        if (timing) check({tag, "_sck_cycles"}, 32'(sck_cnt), 32'd38);
        for (int i = 0; i < 160; i++) begin
            samp[i] = uo_out[4];
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) b[k] = samp[16 * k + 24];
        check({tag, "_startbit"}, 32'(samp[8]), 32'd0);
        check({tag, "_data"}, 32'(b), 32'(exp));
        check({tag, "_stopbit"}, 32'(samp[152]), 32'd1);
        if (timing) begin
            check({tag, "_start_end"}, 32'(samp[15]), 32'd0);
            check({tag, "_bit0_begin"}, 32'(samp[16]), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        ena = 1'b1;
        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_uo", 32'(uo_out), 32'h11);
        check("rst_uio", 32'(uio_out), 32'hC1);
        check("rst_oe", 32'(uio_oe), 32'hC9);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle_uo", 32'(uo_out), 32'h11);
        ui_in = 8'h01;
        @(negedge clk);
        ui_in = 8'h00;
        check("cmd_uio", 32'(uio_out), 32'hC0);
        check("cmd_oe", 32'(uio_oe), 32'hCB);
        check("cmd_uo", 32'(uo_out), 32'h31);
        rx_byte("b0", 8'hA5, 1'b1);
        check("cmd_byte", 32'(cmd), 32'h6B);
        check("addr", 32'(addr), 32'h0);
        rx_byte("b1", 8'h3C, 1'b0);
        rx_byte("b2", 8'h81, 1'b0);
        check("pre_done", 32'(uo_out[6]), 32'd0);
`ifdef SPI_MIRROR_EN
        check("spi_byte", 32'(spi_last), 32'h81);
        check("spi_cs_len", 32'(spi_len_last), 32'd16);
`endif
        rx_byte("b3", 8'h5A, 1'b0);
        check("done_uo", 32'(uo_out), 32'h51);
        check("done_uio", 32'(uio_out), 32'hC1);
        check("done_oe", 32'(uio_oe), 32'hC9);
        ui_in = 8'h01;
        repeat (10) @(negedge clk);
        ui_in = 8'h00;
        repeat (10) @(negedge clk);
        check("restart_falls", 32'(cs_falls), 32'd1);
        check("restart_uo", 32'(uo_out), 32'h51);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h01;
        @(negedge clk);
        ui_in = 8'h00;
        n = 0;
        while (uo_out[4] !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_data", 32'(n < 4000), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_uo", 32'(uo_out), 32'h11);
        check("abort_uio", 32'(uio_out), 32'hC1);
        check("abort_oe", 32'(uio_oe), 32'hC9);
        rst_n = 1'b0;
        ui_in = 8'h01;
        @(negedge clk);
        ui_in = 8'h00;
        rx_byte("replay", 8'hA5, 1'b1);
        check("replay_cmd", 32'(cmd), 32'h6B);
        check("replay_addr", 32'(addr), 32'h0);
        check("replay_falls", 32'(cs_falls), 32'd3);
        check("invariants", 32'(inv_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
